// File: rtl/tms34020_scrref_ctrl_pkg.sv
// Shared types and constants for the screen-refresh transfer controller.
// Contents: transfer type encoding, controller FSM states, refresh backlog limit.
// No ports; imported by the interface, FIFO and top-level controller.
package tms34020_scrref_ctrl_pkg;

  typedef enum logic [1:0] {
    XFER_NONE = 2'b00,
    XFER_SCR  = 2'b01,
    XFER_DRF  = 2'b10
  } MemXferType_t;

  typedef enum logic {
    SR_IDLE = 1'b0,
    SR_REQ  = 1'b1
  } ScrRefState_t;

  // A backlog this deep makes refresh urgent and lets it pre-empt screen traffic.
  localparam logic [1:0] REF_PEND_MAX = 2'd3;

endpackage

// File: rtl/tms34020_scrref_ctrl_if.sv
// Memory-arbiter request bus: REQ/ACK handshake carrying transfer type and address.
// master: drives mem_req/mem_type/mem_addr, samples mem_ack (the controller).
// slave : samples the request, drives mem_ack (the arbiter).
interface tms34020_scrref_ctrl_if;
  import tms34020_scrref_ctrl_pkg::*;

  logic         mem_req;
  MemXferType_t mem_type;
  logic [31:0]  mem_addr;
  logic         mem_ack;

  modport master (output mem_req, output mem_type, output mem_addr, input mem_ack);
  modport slave  (input mem_req, input mem_type, input mem_addr, output mem_ack);

endinterface

// File: rtl/tms34020_scrref_ctrl_fifo.sv
// Synchronous request FIFO (module tms34020_scrref_fifo), clock-enable qualified.
// Ports: clk_i/rst_i, ce_i gates both sides; push_i/dat_i write, pop_i/dat_o read head;
//        full_o/empty_o/lvl_o report occupancy. A push on full is taken only with a pop.
module tms34020_scrref_fifo #(
  parameter int DEPTH = 2,
  parameter int DW    = 27
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   ce_i,
  input  logic                   push_i,
  input  logic [DW-1:0]          dat_i,
  input  logic                   pop_i,
  output logic [DW-1:0]          dat_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] lvl_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   cnt_q;
  logic          wr_en, rd_en;

  assign full_o  = (cnt_q == FULL_CNT);
  assign empty_o = (cnt_q == '0);
  assign lvl_o   = cnt_q;
  assign dat_o   = mem_q[rd_ptr_q];

  assign rd_en = ce_i & pop_i & ~empty_o;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign wr_en = ce_i & push_i & (~full_o | rd_en);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (wr_en && !rd_en)      cnt_q <= cnt_q + 1'b1;
      else if (rd_en && !wr_en) cnt_q <= cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wr_ptr_q] <= dat_i;
  end

endmodule

// File: rtl/tms34020_scrref_ctrl.sv
// Screen-refresh transfer controller: buffers SCRREF requests, issues them to the memory
// arbiter over REQ/ACK, optionally interleaving periodic DRAM refresh (TMS34020_DRAM_REFRESH_EN).
// Ports: clk_i/rst_i, en_i & ce_r_i qualify every state change; scrref_run_i/scrref_addr_i push
//        requests; ref_interval_i sets refresh period; mem_if is the arbiter bus; ovf_o/ovf_clr_i
//        sticky drop flag; fifo_lvl_o buffer occupancy.
module tms34020_scrref_ctrl
  import tms34020_scrref_ctrl_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  parameter int REF_ROW_W  = 10
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        en_i,
  input  logic                        ce_r_i,
  input  logic                        scrref_run_i,
  input  logic [31:0]                 scrref_addr_i,
  input  logic [7:0]                  ref_interval_i,
  tms34020_scrref_ctrl_if.master      mem_if,
  output logic                        ovf_o,
  input  logic                        ovf_clr_i,
  output logic [$clog2(FIFO_DEPTH):0] fifo_lvl_o
);
  logic         tick, ack_tick, pop, drop, full, empty;
  logic [26:0]  head;
  ScrRefState_t state_q, state_d;
  logic         req_q, req_d, ovf_q, ovf_d;
  MemXferType_t type_q, type_d;
  logic [31:0]  addr_q, addr_d;
  logic [1:0]   ref_pend;
  logic [31:0]  ref_addr;
  logic         unused_addr_lsb;

  assign tick     = en_i & ce_r_i;
  assign ack_tick = tick & (state_q == SR_REQ) & mem_if.mem_ack;
  assign pop      = ack_tick & (type_q == XFER_SCR);
  assign drop     = tick & scrref_run_i & full & ~pop;
  // YZCNT is not part of the transfer address; the row base is 32-word aligned.
  assign unused_addr_lsb = ^scrref_addr_i[4:0];

  tms34020_scrref_fifo #(.DEPTH(FIFO_DEPTH), .DW(27)) u_fifo (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .ce_i   (tick),
    .push_i (scrref_run_i),
    .dat_i  (scrref_addr_i[31:5]),
    .pop_i  (pop),
    .dat_o  (head),
    .full_o (full),
    .empty_o(empty),
    .lvl_o  (fifo_lvl_o)
  );

`ifdef TMS34020_DRAM_REFRESH_EN
  logic [7:0]           ref_cnt_q, ref_cnt_d;
  logic [1:0]           ref_pend_q, ref_pend_d;
  logic [REF_ROW_W-1:0] ref_row_q, ref_row_d;
  logic                 ref_gen, ref_retire;

  assign ref_retire = ack_tick & (type_q == XFER_DRF);

  always_comb begin
    ref_cnt_d  = ref_cnt_q;
    ref_pend_d = ref_pend_q;
    ref_row_d  = ref_row_q;
    ref_gen    = 1'b0;
    if (tick) begin
      if (ref_interval_i == 8'd0) begin
        ref_cnt_d = 8'd0;
      end else if (ref_cnt_q == 8'd0) begin
        ref_cnt_d = ref_interval_i - 8'd1;
        ref_gen   = 1'b1;
      end else begin
        ref_cnt_d = ref_cnt_q - 8'd1;
      end
    end
    // New refresh and a retired one cancel out; backlog saturates at the urgent level.
    if (ref_gen && !ref_retire) begin
      if (ref_pend_q != REF_PEND_MAX) ref_pend_d = ref_pend_q + 2'd1;
    end else if (ref_retire && !ref_gen) begin
      ref_pend_d = ref_pend_q - 2'd1;
    end
    if (ref_retire) ref_row_d = ref_row_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ref_cnt_q  <= 8'd0;
      ref_pend_q <= 2'd0;
      ref_row_q  <= '0;
    end else begin
      ref_cnt_q  <= ref_cnt_d;
      ref_pend_q <= ref_pend_d;
      ref_row_q  <= ref_row_d;
    end
  end

  assign ref_pend = ref_pend_q;
  assign ref_addr = 32'({ref_row_q, 5'b0});
`else
  logic unused_ref_interval;
  assign unused_ref_interval = ^ref_interval_i;
  assign ref_pend = 2'd0;
  assign ref_addr = 32'd0;
`endif

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    type_d  = type_q;
    addr_d  = addr_q;
    ovf_d   = ovf_q;
    if (drop)                  ovf_d = 1'b1;
    else if (tick & ovf_clr_i) ovf_d = 1'b0;
    if (tick) begin
      case (state_q)
        SR_IDLE: begin
          if (ref_pend == REF_PEND_MAX) begin
            state_d = SR_REQ; req_d = 1'b1; type_d = XFER_DRF; addr_d = ref_addr;
          end else if (!empty) begin
            state_d = SR_REQ; req_d = 1'b1; type_d = XFER_SCR; addr_d = {head, 5'b0};
          end else if (ref_pend != 2'd0) begin
            state_d = SR_REQ; req_d = 1'b1; type_d = XFER_DRF; addr_d = ref_addr;
          end
        end
        SR_REQ: begin
          if (mem_if.mem_ack) begin
            state_d = SR_IDLE; req_d = 1'b0; type_d = XFER_NONE;
          end
        end
        default: state_d = SR_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= SR_IDLE;
      req_q   <= 1'b0;
      type_q  <= XFER_NONE;
      addr_q  <= 32'd0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      type_q  <= type_d;
      addr_q  <= addr_d;
      ovf_q   <= ovf_d;
    end
  end

  assign mem_if.mem_req  = req_q;
  assign mem_if.mem_type = type_q;
  assign mem_if.mem_addr = addr_q;
  assign ovf_o           = ovf_q;

endmodule

// File: tb/tb_tms34020_scrref_ctrl.sv
// Bench for tms34020_scrref_ctrl: directed scenarios plus random traffic against a queue model.
// Refresh scenarios are built only with TMS34020_DRAM_REFRESH_EN.
// Ports: none.
module tb_tms34020_scrref_ctrl;
  import tms34020_scrref_ctrl_pkg::*;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst, en, ce_r, run, ovf_clr, ovf;
  logic [31:0] saddr;
  logic [7:0]  ref_int;
  logic [1:0]  lvl;
  int          total = 0;
  int          bad   = 0;

  tms34020_scrref_ctrl_if mem_if();

  tms34020_scrref_ctrl #(.FIFO_DEPTH(DEPTH), .REF_ROW_W(10)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .en_i          (en),
    .ce_r_i        (ce_r),
    .scrref_run_i  (run),
    .scrref_addr_i (saddr),
    .ref_interval_i(ref_int),
    .mem_if        (mem_if),
    .ovf_o         (ovf),
    .ovf_clr_i     (ovf_clr),
    .fifo_lvl_o    (lvl)
  );

  always #5 clk = ~clk;

  // Reference model: pending screen addresses, the transfer in flight, refresh bookkeeping.
  logic [31:0] m_q[$];
  bit          m_busy;
  int          m_type;
  logic [31:0] m_addr;
  bit          m_ovf;
  int          m_pend, m_cnt, m_row;

  function automatic void model_reset();
    m_q.delete();
    m_busy = 0; m_type = 0; m_addr = 0; m_ovf = 0;
    m_pend = 0; m_cnt = 0; m_row = 0;
  endfunction

  function automatic void model_tick();
    bit full, pop, ret, gen;
    int p0;
    full = (m_q.size() == DEPTH);
    pop  = m_busy && (m_type == 1) && mem_if.mem_ack;
    ret  = m_busy && (m_type == 2) && mem_if.mem_ack;
    p0   = m_pend;
    gen  = 0;
`ifdef TMS34020_DRAM_REFRESH_EN
    if (ref_int == 0) m_cnt = 0;
    else if (m_cnt == 0) begin m_cnt = int'(ref_int) - 1; gen = 1; end
    else m_cnt = m_cnt - 1;
`endif
    if (!m_busy) begin
      if (p0 == 3) begin
        m_busy = 1; m_type = 2; m_addr = 32'(m_row) << 5;
      end else if (m_q.size() > 0) begin
        m_busy = 1; m_type = 1; m_addr = m_q[0];
      end else if (p0 > 0) begin
        m_busy = 1; m_type = 2; m_addr = 32'(m_row) << 5;
      end
    end else if (mem_if.mem_ack) begin
      m_busy = 0;
    end
    if (pop) void'(m_q.pop_front());
    if (ret) m_row = (m_row + 1) % 1024;
    if (gen && !ret)      m_pend = (p0 == 3) ? 3 : p0 + 1;
    else if (ret && !gen) m_pend = p0 - 1;
    if (run && (!full || pop)) m_q.push_back({saddr[31:5], 5'b0});
    if (run && full && !pop) m_ovf = 1;
    else if (ovf_clr)        m_ovf = 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string t);
    chk({t, ".req"},  32'(mem_if.mem_req), 32'(m_busy));
    chk({t, ".type"}, 32'(mem_if.mem_type), m_busy ? 32'(m_type) : 32'd0);
    chk({t, ".addr"}, mem_if.mem_addr, m_addr);
    chk({t, ".ovf"},  32'(ovf), 32'(m_ovf));
    chk({t, ".lvl"},  32'(lvl), 32'(m_q.size()));
  endtask

  // Apply one clock with the given inputs, advance the model, then compare.
  task automatic step(input bit r, input logic [31:0] a, input bit k, input bit c);
    run = r; saddr = a; mem_if.mem_ack = k; ovf_clr = c;
    @(posedge clk);
    if (rst) model_reset();
    else if (en && ce_r) model_tick();
    #1;
    check_all("step");
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(0, 32'd0, 0, 0);
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] got[$];
    int          got_t[$];
    bit          prev_req;
    rst = 1'b1; en = 1'b1; ce_r = 1'b1; run = 1'b0; saddr = '0;
    mem_if.mem_ack = 1'b0; ovf_clr = 1'b0; ref_int = 8'd0;
    model_reset();
    do_reset();
    chk("rst.req",  32'(mem_if.mem_req), 32'd0);
    chk("rst.type", 32'(mem_if.mem_type), 32'd0);
    chk("rst.addr", mem_if.mem_addr, 32'd0);
    chk("rst.ovf",  32'(ovf), 32'd0);
    chk("rst.lvl",  32'(lvl), 32'd0);

    // Single request, acknowledged two ticks after the push.
    step(1, 32'h0012_345F, 0, 0);
    chk("single.lvl1", 32'(lvl), 32'd1);
    chk("single.req0", 32'(mem_if.mem_req), 32'd0);
    step(0, 32'd0, 0, 0);
    chk("single.req",  32'(mem_if.mem_req), 32'd1);
    chk("single.type", 32'(mem_if.mem_type), 32'd1);
    chk("single.addr", mem_if.mem_addr, 32'h0012_3440);
    step(0, 32'd0, 1, 0);
    chk("single.reqlow", 32'(mem_if.mem_req), 32'd0);
    chk("single.lvl0",   32'(lvl), 32'd0);

    // Overflow: three pushes, no ACK.
    step(1, 32'hAAAA_0001, 0, 0);
    step(1, 32'hBBBB_0002, 0, 0);
    step(1, 32'hCCCC_0003, 0, 0);
    chk("ovf.lvl",  32'(lvl), 32'd2);
    chk("ovf.flag", 32'(ovf), 32'd1);
    chk("ovf.addrA", mem_if.mem_addr, 32'hAAAA_0000);
    step(0, 32'd0, 1, 0);
    step(0, 32'd0, 0, 0);
    chk("ovf.addrB", mem_if.mem_addr, 32'hBBBB_0000);
    step(0, 32'd0, 1, 0);
    step(0, 32'd0, 0, 1);
    chk("ovf.clr", 32'(ovf), 32'd0);

    // Full buffer with push and ACK on the same tick.
    step(1, 32'h1111_1111, 0, 0);
    step(1, 32'h2222_2222, 0, 0);
    step(1, 32'h3333_3333, 1, 0);
    chk("fullpp.lvl", 32'(lvl), 32'd2);
    chk("fullpp.ovf", 32'(ovf), 32'd0);
    repeat (4) step(0, 32'd0, 1, 0);

    // Enable gating freezes everything, including a held request.
    step(1, 32'h4444_4444, 0, 0);
    step(0, 32'd0, 0, 0);
    en = 1'b0;
    step(1, 32'h5555_5555, 1, 1);
    chk("frz.req", 32'(mem_if.mem_req), 32'd1);
    chk("frz.lvl", 32'(lvl), 32'd1);
    en = 1'b1; ce_r = 1'b0;
    step(1, 32'h6666_6666, 1, 0);
    ce_r = 1'b1;

    // Reset while a request is outstanding.
    chk("rstreq.pre", 32'(mem_if.mem_req), 32'd1);
    do_reset();
    chk("rstreq.req",  32'(mem_if.mem_req), 32'd0);
    chk("rstreq.type", 32'(mem_if.mem_type), 32'd0);
    chk("rstreq.addr", mem_if.mem_addr, 32'd0);
    chk("rstreq.lvl",  32'(lvl), 32'd0);

`ifdef TMS34020_DRAM_REFRESH_EN
    // Periodic refresh, immediate ACK; row counter wraps after 1024 rows.
    ref_int = 8'd4;
    prev_req = 1'b0;
    for (int i = 0; i < 4130; i++) begin
      step(0, 32'd0, 1, 0);
      if (mem_if.mem_req && !prev_req && mem_if.mem_type == XFER_DRF) begin
        got.push_back(mem_if.mem_addr);
        got_t.push_back(i);
      end
      prev_req = mem_if.mem_req;
    end
    chk("drf.count", 32'(got.size() >= 1025), 32'd1);
    chk("drf.a0", got[0], 32'h0);
    chk("drf.a1", got[1], 32'h20);
    chk("drf.a2", got[2], 32'h40);
    chk("drf.gap", 32'(got_t[1] - got_t[0]), 32'd4);
    chk("drf.a1023", got[1023], 32'h7FE0);
    chk("drf.wrap", got[1024], 32'h0);

    // Urgency: screen beats a single pending refresh, a full backlog beats screen.
    ref_int = 8'd0;
    do_reset();
    ref_int = 8'd1;
    step(1, 32'h7000_0000, 0, 0);
    step(1, 32'h7100_0000, 0, 0);
    chk("urg.scrfirst", 32'(mem_if.mem_type), 32'd1);
    step(0, 32'd0, 0, 0);
    step(0, 32'd0, 1, 0);
    step(0, 32'd0, 0, 0);
    chk("urg.drffirst", 32'(mem_if.mem_type), 32'd2);
    chk("urg.lvl", 32'(lvl), 32'd1);
    repeat (6) step(0, 32'd0, 1, 0);
    ref_int = 8'd0;
`endif

    // Random traffic with random gating, ACKs, clears and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      en   = ($urandom_range(0, 9) != 0);
      ce_r = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 199) == 0) ref_int = 8'($urandom_range(0, 6));
      if ($urandom_range(0, 499) == 0) do_reset();
      step(1'($urandom_range(0, 1)), $urandom(), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 7) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
